// File: rtl/button_repeat_debounce_if.sv
// Button conditioner bus: the raw pin in, and the conditioned strobes out.
// The master drives the pin, and the slave (the conditioner) drives the results.
interface button_repeat_debounce_if;
  logic btn_in;
  logic pulse;
  logic held;
  logic repeating;

  modport master (
    output btn_in,
    input  pulse,
    input  held,
    input  repeating
  );

  modport slave (
    input  btn_in,
    output pulse,
    output held,
    output repeating
  );
endinterface

// File: rtl/button_repeat_debounce.sv
// Push-button front end for the VGA clock adjust inputs.
// The raw pin is synchronised and then debounced.
// A single-cycle increment pulse is issued on each accepted press.
// While the button stays held, further pulses auto-repeat: the first after
// REPEAT_DELAY cycles, then one every REPEAT_PERIOD cycles.
module button_repeat_debounce #(
  parameter int DEBOUNCE_CYCLES = 315_000,
  parameter int REPEAT_DELAY    = 15_750_000,
  parameter int REPEAT_PERIOD   = 3_150_000,
  parameter int REPEAT_EN       = 1,
  parameter int ACTIVE_LOW      = 0
) (
  input logic                     clk,
  input logic                     reset,
  button_repeat_debounce_if.slave btn
);

  localparam int DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int TM_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int TM_W   = $clog2(TM_MAX);

  localparam logic [DB_W-1:0] DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DB_W-1:0] DB_ONE     = DB_W'(1);
  localparam logic [TM_W-1:0] DELAY_LAST = TM_W'(REPEAT_DELAY - 1);
  localparam logic [TM_W-1:0] PERIOD_LAST = TM_W'(REPEAT_PERIOD - 1);
  localparam logic [TM_W-1:0] TM_ONE     = TM_W'(1);
  localparam logic            INVERT     = (ACTIVE_LOW != 0);
  localparam logic            REP_ON     = (REPEAT_EN != 0);

  localparam logic [1:0] IDLE       = 2'd0;
  localparam logic [1:0] WAIT_DELAY = 2'd1;
  localparam logic [1:0] REPEAT     = 2'd2;

  logic [1:0]      sync_q;
  logic            s;
  logic            db;
  logic [DB_W-1:0] db_cnt;
  logic [1:0]      state;
  logic [TM_W-1:0] timer;
  logic            pulse_q;
  logic            repeating_q;

  assign s = sync_q[1];

  // Two-flop synchroniser on the polarity-corrected pin.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], btn.btn_in ^ INVERT};
    end
  end

  // Debouncer: a change is accepted only after DEBOUNCE_CYCLES consecutive differing samples.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      db     <= 1'b0;
      db_cnt <= '0;
    end else if (s == db) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_LAST) begin
      db     <= s;
      db_cnt <= '0;
    end else begin
      db_cnt <= db_cnt + DB_ONE;
    end
  end

  // Press/repeat FSM: the pulse is issued on press, then after the delay, then once every period. Release has priority.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      timer       <= '0;
      pulse_q     <= 1'b0;
      repeating_q <= 1'b0;
    end else begin
      pulse_q <= 1'b0;
      case (state)
        IDLE: begin
          if (db) begin
            pulse_q <= 1'b1;
            timer   <= '0;
            state   <= WAIT_DELAY;
          end
        end
        WAIT_DELAY: begin
          if (!db) begin
            state <= IDLE;
            timer <= '0;
          end else if (REP_ON) begin
            if (timer == DELAY_LAST) begin
              pulse_q     <= 1'b1;
              timer       <= '0;
              state       <= REPEAT;
              repeating_q <= 1'b1;
            end else begin
              timer <= timer + TM_ONE;
            end
          end else begin
            timer <= '0;
          end
        end
        REPEAT: begin
          if (!db) begin
            state       <= IDLE;
            timer       <= '0;
            repeating_q <= 1'b0;
          end else if (timer == PERIOD_LAST) begin
            pulse_q <= 1'b1;
            timer   <= '0;
          end else begin
            timer <= timer + TM_ONE;
          end
        end
        default: begin
          state       <= IDLE;
          timer       <= '0;
          repeating_q <= 1'b0;
        end
      endcase
    end
  end

  assign btn.pulse     = pulse_q;
  assign btn.held      = db;
  assign btn.repeating = repeating_q;

endmodule

// File: tb/tb_button_repeat_debounce.sv
// Directed testbench for button_repeat_debounce.
// Small timing parameters are used: debounce 4, delay 10, period 3.
// There are three instances: the default instance, one with repeat disabled, and one with an active-low pin.
module tb_button_repeat_debounce;

  logic clk;
  logic reset;
  int   tests_run;
  int   tests_failed;

  button_repeat_debounce_if ifa ();
  button_repeat_debounce_if ifn ();
  button_repeat_debounce_if ifl ();

  button_repeat_debounce #(
    .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(10), .REPEAT_PERIOD(3),
    .REPEAT_EN(1), .ACTIVE_LOW(0)
  ) dut (
    .clk(clk), .reset(reset), .btn(ifa.slave)
  );

  button_repeat_debounce #(
    .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(10), .REPEAT_PERIOD(3),
    .REPEAT_EN(0), .ACTIVE_LOW(0)
  ) dut_norep (
    .clk(clk), .reset(reset), .btn(ifn.slave)
  );

  button_repeat_debounce #(
    .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(10), .REPEAT_PERIOD(3),
    .REPEAT_EN(1), .ACTIVE_LOW(1)
  ) dut_al (
    .clk(clk), .reset(reset), .btn(ifl.slave)
  );

  // 100 MHz-style clock, period 10
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic test_reset;
    logic [2:0] obs;
    logic [2:0] exp_v;
    #12;
    obs = {ifa.pulse, ifa.held, ifa.repeating};
    tests_run++;
    if (obs !== 3'b000) begin
      tests_failed++;
      $display("[TB] FAIL reset_state_a got %b expected 000", obs);
    end
    obs = {ifn.pulse, ifn.held, ifn.repeating};
    tests_run++;
    if (obs !== 3'b000) begin
      tests_failed++;
      $display("[TB] FAIL reset_state_n got %b expected 000", obs);
    end
    obs = {ifl.pulse, ifl.held, ifl.repeating};
    tests_run++;
    if (obs !== 3'b000) begin
      tests_failed++;
      $display("[TB] FAIL reset_state_l got %b expected 000", obs);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    ifa.btn_in = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    tests_run++;
    if (ifa.held !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL pre_reset_held got %b expected 1", ifa.held);
    end
    #2;
    reset = 1'b1;
    #1;
    obs = {ifa.pulse, ifa.held, ifa.repeating};
    tests_run++;
    if (obs !== 3'b000) begin
      tests_failed++;
      $display("[TB] FAIL async_reset got %b expected 000", obs);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      @(posedge clk);
      #1;
      exp_v = {(e == 7), (e >= 6), 1'b0};
      obs = {ifa.pulse, ifa.held, ifa.repeating};
      tests_run++;
      if (obs !== exp_v) begin
        tests_failed++;
        $display("[TB] FAIL post_reset_edge%0d got %b expected %b", e, obs, exp_v);
      end
    end
    ifa.btn_in = 1'b0;
    repeat (30) @(negedge clk);
  endtask

  task automatic test_glitch;
    int pulses;
    pulses = 0;
    @(negedge clk);
    for (int e = 1; e <= 25; e++) begin
      ifa.btn_in = ((e >= 1 && e <= 3) || (e >= 6 && e <= 8));
      @(posedge clk);
      #1;
      if (ifa.pulse === 1'b1) pulses++;
      tests_run++;
      if (ifa.held !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL glitch_held_edge%0d got %b expected 0", e, ifa.held);
      end
      @(negedge clk);
    end
    ifa.btn_in = 1'b0;
    tests_run++;
    if (pulses != 0) begin
      tests_failed++;
      $display("[TB] FAIL glitch_pulses got %0d expected 0", pulses);
    end
    repeat (10) @(negedge clk);
  endtask

  task automatic test_short_press;
    logic [2:0] obs;
    logic [2:0] exp_v;
    @(negedge clk);
    ifa.btn_in = 1'b1;
    for (int e = 1; e <= 30; e++) begin
      @(posedge clk);
      #1;
      if (e == 8) ifa.btn_in = 1'b0;
      exp_v = {(e == 7), (e >= 6 && e <= 13), 1'b0};
      obs = {ifa.pulse, ifa.held, ifa.repeating};
      tests_run++;
      if (obs !== exp_v) begin
        tests_failed++;
        $display("[TB] FAIL short_press_edge%0d got %b expected %b", e, obs, exp_v);
      end
    end
    repeat (5) @(negedge clk);
  endtask

  task automatic test_long_hold;
    logic [2:0] obs;
    logic [2:0] exp_v;
    logic       exp_p;
    int         pulses;
    pulses = 0;
    @(negedge clk);
    ifa.btn_in = 1'b1;
    for (int e = 1; e <= 55; e++) begin
      @(posedge clk);
      #1;
      if (e == 40) ifa.btn_in = 1'b0;
      exp_p = (e == 7) || (e == 17) || (e >= 20 && e <= 44 && ((e - 20) % 3) == 0);
      exp_v = {exp_p, (e >= 6 && e <= 45), (e >= 17 && e <= 46)};
      obs = {ifa.pulse, ifa.held, ifa.repeating};
      if (ifa.pulse === 1'b1) pulses++;
      tests_run++;
      if (obs !== exp_v) begin
        tests_failed++;
        $display("[TB] FAIL long_hold_edge%0d got %b expected %b", e, obs, exp_v);
      end
    end
    tests_run++;
    if (pulses != 11) begin
      tests_failed++;
      $display("[TB] FAIL long_hold_pulses got %0d expected 11", pulses);
    end
    repeat (5) @(negedge clk);
  endtask

  task automatic test_no_repeat;
    logic [2:0] obs;
    logic [2:0] exp_v;
    int         pulses;
    pulses = 0;
    @(negedge clk);
    ifn.btn_in = 1'b1;
    for (int e = 1; e <= 55; e++) begin
      @(posedge clk);
      #1;
      if (e == 40) ifn.btn_in = 1'b0;
      exp_v = {(e == 7), (e >= 6 && e <= 45), 1'b0};
      obs = {ifn.pulse, ifn.held, ifn.repeating};
      if (ifn.pulse === 1'b1) pulses++;
      tests_run++;
      if (obs !== exp_v) begin
        tests_failed++;
        $display("[TB] FAIL no_repeat_edge%0d got %b expected %b", e, obs, exp_v);
      end
    end
    tests_run++;
    if (pulses != 1) begin
      tests_failed++;
      $display("[TB] FAIL no_repeat_pulses got %0d expected 1", pulses);
    end
    repeat (5) @(negedge clk);
  endtask

  task automatic test_active_low;
    logic [2:0] obs;
    logic [2:0] exp_v;
    @(negedge clk);
    ifl.btn_in = 1'b0;
    for (int e = 1; e <= 30; e++) begin
      @(posedge clk);
      #1;
      if (e == 8) ifl.btn_in = 1'b1;
      exp_v = {(e == 7), (e >= 6 && e <= 13), 1'b0};
      obs = {ifl.pulse, ifl.held, ifl.repeating};
      tests_run++;
      if (obs !== exp_v) begin
        tests_failed++;
        $display("[TB] FAIL active_low_edge%0d got %b expected %b", e, obs, exp_v);
      end
    end
    repeat (5) @(negedge clk);
  endtask

  // Scenario sequence followed by the summary line
  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset        = 1'b1;
    ifa.btn_in   = 1'b0;
    ifn.btn_in   = 1'b0;
    ifl.btn_in   = 1'b1;
    test_reset();
    test_glitch();
    test_short_press();
    test_long_hold();
    test_no_repeat();
    test_active_low();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
